// File: rtl/reg_dest_pkg.sv
// ---------------------------------------------------------------------------
// reg_dest_pkg
// Shared definitions for the register-destination tracker:
//   - dest_sel encodings (SEL_RT, SEL_RD, SEL_RA, SEL_SP, SEL_RS)
//   - default fixed destinations for $ra and $sp
//   - stage_t: one writeback delay-line slot {valid, addr}
// ---------------------------------------------------------------------------
package reg_dest_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_RA_REG     = 31;
    localparam int DEF_SP_REG     = 29;

    localparam logic [2:0] SEL_RT = 3'b000;
    localparam logic [2:0] SEL_RD = 3'b001;
    localparam logic [2:0] SEL_RA = 3'b010;
    localparam logic [2:0] SEL_SP = 3'b011;
    localparam logic [2:0] SEL_RS = 3'b100;

    // The address field is sized by the default register address width; the
    // tracker is built with REG_ADDR_W equal to this value.
    typedef struct packed {
        logic                      valid;
        logic [DEF_REG_ADDR_W-1:0] addr;
    } stage_t;

endpackage

// File: rtl/reg_dest_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_dest_scoreboard
// Per-register pending-write counters with busy vector and two hazard
// lookups.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   flush_i           : clears every counter (overrides inc/dec)
//   inc_en_i/addr_i   : tracked issue accepted this cycle
//   dec_en_i/addr_i   : retire (writeback strobe) this cycle
//   src_a_i, src_b_i  : source registers to look up
//   busy_vec_o        : bit i set while register i has a pending write
//   hazard_a_o/b_o    : pending-write flag for each source
// Optional macro REG_DEST_TRACK_BYPASS_EN: a hazard is suppressed when the
// only pending write to that source is retiring in the current cycle.
// ---------------------------------------------------------------------------
module reg_dest_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int PIPE_DEPTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  inc_en_i,
    input  logic [REG_ADDR_W-1:0] inc_addr_i,
    input  logic                  dec_en_i,
    input  logic [REG_ADDR_W-1:0] dec_addr_i,
    input  logic [REG_ADDR_W-1:0] src_a_i,
    input  logic [REG_ADDR_W-1:0] src_b_i,
    output logic [NUM_REGS-1:0]   busy_vec_o,
    output logic                  hazard_a_o,
    output logic                  hazard_b_o
);

    localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    // Simultaneous inc and dec on one register cancel. Register 0 is hardwired
    // to zero and never counted.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (flush_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if ((inc_en_i && (inc_addr_i == REG_ADDR_W'(i))) &&
                    !(dec_en_i && (dec_addr_i == REG_ADDR_W'(i)))) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else if ((dec_en_i && (dec_addr_i == REG_ADDR_W'(i))) &&
                             !(inc_en_i && (inc_addr_i == REG_ADDR_W'(i)))) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        busy_vec_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_vec_o[i] = (cnt_q[i] != '0);
        end
    end

`ifdef REG_DEST_TRACK_BYPASS_EN
    // Write-through in the register file delivers the retiring value this
    // cycle, so the last outstanding write no longer blocks its readers.
    assign hazard_a_o = busy_vec_o[src_a_i] &&
                        !((cnt_q[src_a_i] == CNT_W'(1)) && dec_en_i && (dec_addr_i == src_a_i));
    assign hazard_b_o = busy_vec_o[src_b_i] &&
                        !((cnt_q[src_b_i] == CNT_W'(1)) && dec_en_i && (dec_addr_i == src_b_i));
`else
    assign hazard_a_o = busy_vec_o[src_a_i];
    assign hazard_b_o = busy_vec_o[src_b_i];
`endif

endmodule

// File: rtl/reg_dest_track.sv
// ---------------------------------------------------------------------------
// reg_dest_track
// Selects the write-destination register, carries it through a PIPE_DEPTH
// stage writeback delay line and keeps a pending-write scoreboard for RAW
// hazard detection on two source operands.
//   clk, reset            : clock, asynchronous active-high reset
//   issue_valid/issue_wr  : instruction presented / writes a register
//   dest_sel              : 000 rt, 001 rd, 010 RA_REG, 011 SP_REG, 100 rs
//   inst25_21/20_16/15_11 : rs / rt / rd fields
//   stall, flush          : freeze delay line / discard everything in flight
//   src_a, src_b          : source registers to check
//   dest_addr             : combinational selected destination (0 if illegal)
//   dest_err              : one-cycle pulse after accepting an illegal sel
//   wb_valid, wb_addr     : writeback strobe and address
//   hazard_a/b, busy_vec  : scoreboard outputs
// Optional macro REG_DEST_TRACK_BYPASS_EN enables retire-cycle hazard bypass
// (see reg_dest_scoreboard).
// ---------------------------------------------------------------------------
module reg_dest_track
    import reg_dest_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_REGS   = 2 ** REG_ADDR_W,
    parameter int PIPE_DEPTH = 3,
    parameter int RA_REG     = DEF_RA_REG,
    parameter int SP_REG     = DEF_SP_REG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  issue_wr,
    input  logic [2:0]            dest_sel,
    input  logic [REG_ADDR_W-1:0] inst25_21,
    input  logic [REG_ADDR_W-1:0] inst20_16,
    input  logic [REG_ADDR_W-1:0] inst15_11,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] src_a,
    input  logic [REG_ADDR_W-1:0] src_b,
    output logic [REG_ADDR_W-1:0] dest_addr,
    output logic                  dest_err,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  hazard_a,
    output logic                  hazard_b,
    output logic [NUM_REGS-1:0]   busy_vec
);

    logic   sel_legal;
    logic   accept;
    logic   track;
    logic   dest_err_q, dest_err_d;
    stage_t stage_q [PIPE_DEPTH];
    stage_t stage_d [PIPE_DEPTH];

    always_comb begin
        dest_addr = '0;
        sel_legal = 1'b1;
        case (dest_sel)
            SEL_RT:  dest_addr = inst20_16;
            SEL_RD:  dest_addr = inst15_11;
            SEL_RA:  dest_addr = REG_ADDR_W'(RA_REG);
            SEL_SP:  dest_addr = REG_ADDR_W'(SP_REG);
            SEL_RS:  dest_addr = inst25_21;
            default: sel_legal = 1'b0;
        endcase
    end

    assign accept = issue_valid && !stall && !flush;
    // Writes to register 0 and non-writing instructions travel as bubbles.
    assign track  = accept && issue_wr && sel_legal && (dest_addr != '0);

    assign dest_err_d = accept && !sel_legal;

    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (flush) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end else if (!stall) begin
            stage_d[0].valid = track;
            stage_d[0].addr  = track ? dest_addr : '0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_err_q <= 1'b0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            dest_err_q <= dest_err_d;
            stage_q    <= stage_d;
        end
    end

    assign dest_err = dest_err_q;
    // A stalled last stage holds its entry; the strobe is withheld until it moves.
    assign wb_valid = stage_q[PIPE_DEPTH-1].valid && !stall;
    assign wb_addr  = stage_q[PIPE_DEPTH-1].addr;

    reg_dest_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_scoreboard (
        .clk_i      (clk),
        .rst_i      (reset),
        .flush_i    (flush),
        .inc_en_i   (track),
        .inc_addr_i (dest_addr),
        .dec_en_i   (wb_valid),
        .dec_addr_i (wb_addr),
        .src_a_i    (src_a),
        .src_b_i    (src_b),
        .busy_vec_o (busy_vec),
        .hazard_a_o (hazard_a),
        .hazard_b_o (hazard_b)
    );

endmodule

// File: tb/tb_reg_dest_track.sv
module tb_reg_dest_track;

    localparam int AW = 5;
    localparam int NR = 32;
    localparam int D  = 3;

`ifdef REG_DEST_TRACK_BYPASS_EN
    localparam logic HAZ_AT_RETIRE = 1'b0;
`else
    localparam logic HAZ_AT_RETIRE = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid, issue_wr, stall, flush;
    logic [2:0]    dest_sel;
    logic [AW-1:0] inst25_21, inst20_16, inst15_11, src_a, src_b;
    logic [AW-1:0] dest_addr, wb_addr;
    logic          dest_err, wb_valid, hazard_a, hazard_b;
    logic [NR-1:0] busy_vec;

    always #5 clk = ~clk;

    reg_dest_track #(
        .REG_ADDR_W (AW),
        .NUM_REGS   (NR),
        .PIPE_DEPTH (D),
        .RA_REG     (31),
        .SP_REG     (29)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .dest_sel    (dest_sel),
        .inst25_21   (inst25_21),
        .inst20_16   (inst20_16),
        .inst15_11   (inst15_11),
        .stall       (stall),
        .flush       (flush),
        .src_a       (src_a),
        .src_b       (src_b),
        .dest_addr   (dest_addr),
        .dest_err    (dest_err),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .busy_vec    (busy_vec)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: list of pending writes, each with the number of
    // unstalled edges left before it reaches writeback (0 = writing back now).
    typedef struct {
        int addr;
        int rem;
    } pend_t;

    pend_t pend[$];
    logic  err_exp = 1'b0;

    function automatic bit legal_sel(input logic [2:0] s);
        return s <= 3'd4;
    endfunction

    function automatic int ref_dest(input logic [2:0] s, input int rs, input int rt, input int rd);
        case (s)
            3'd0:    return rt;
            3'd1:    return rd;
            3'd2:    return 31;
            3'd3:    return 29;
            3'd4:    return rs;
            default: return 0;
        endcase
    endfunction

    function automatic int pending_count(input int r);
        int n = 0;
        foreach (pend[i]) if (pend[i].addr == r) n++;
        return n;
    endfunction

    task automatic drive(input logic iv, input logic wr, input logic [2:0] sel,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic st, input logic fl,
                         input logic [AW-1:0] sa, input logic [AW-1:0] sb);
        issue_valid = iv;
        issue_wr    = wr;
        dest_sel    = sel;
        inst25_21   = rs;
        inst20_16   = rt;
        inst15_11   = rd;
        stall       = st;
        flush       = fl;
        src_a       = sa;
        src_b       = sb;
    endtask

    task automatic check_cycle();
        int          wa;
        bit          wv;
        logic [31:0] bv;
        logic        ha, hb;
        @(negedge clk);
        wa = 0;
        wv = 1'b0;
        foreach (pend[i]) if (pend[i].rem == 0) begin
            wa = pend[i].addr;
            wv = 1'b1;
        end
        wv = wv && !stall;
        bv = '0;
        for (int r = 1; r < NR; r++) bv[r] = (pending_count(r) != 0);
        ha = bv[src_a];
        hb = bv[src_b];
`ifdef REG_DEST_TRACK_BYPASS_EN
        if (pending_count(int'(src_a)) == 1 && wv && wa == int'(src_a)) ha = 1'b0;
        if (pending_count(int'(src_b)) == 1 && wv && wa == int'(src_b)) hb = 1'b0;
`endif
        check_val("dest_addr", 32'(dest_addr),
                  32'(ref_dest(dest_sel, int'(inst25_21), int'(inst20_16), int'(inst15_11))));
        check_val("dest_err", 32'(dest_err), 32'(err_exp));
        check_val("wb_valid", 32'(wb_valid), 32'(wv));
        check_val("wb_addr", 32'(wb_addr), 32'(wa));
        check_val("busy_vec", busy_vec, bv);
        check_val("hazard_a", 32'(hazard_a), 32'(ha));
        check_val("hazard_b", 32'(hazard_b), 32'(hb));
    endtask

    task automatic advance();
        int d;
        @(posedge clk);
        if (flush) begin
            pend.delete();
            err_exp = 1'b0;
        end else if (stall) begin
            err_exp = 1'b0;
        end else begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].rem == 0) pend.delete(i);
                else pend[i].rem--;
            end
            err_exp = issue_valid && !legal_sel(dest_sel);
            d = ref_dest(dest_sel, int'(inst25_21), int'(inst20_16), int'(inst15_11));
            if (issue_valid && issue_wr && legal_sel(dest_sel) && d != 0)
                pend.push_back('{addr: d, rem: D - 1});
        end
        #1;
    endtask

    task automatic cyc(input logic iv, input logic wr, input logic [2:0] sel, input logic [AW-1:0] rd,
                       input logic st, input logic fl, input logic [AW-1:0] sa);
        drive(iv, wr, sel, 5'd3, 5'd4, rd, st, fl, sa, 5'd0);
        check_cycle();
        advance();
    endtask

    task automatic idle(input int n, input logic [AW-1:0] sa);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, sa);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        #1;
        check_cycle();
        check_val("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_val("rst_busy_vec", busy_vec, 32'd0);
        #1 reset = 1'b0;
        advance();

        // rd=9 issue: busy from cycle 1, writeback in cycle 3, free in cycle 4
        cyc(1'b1, 1'b1, 3'd1, 5'd9, 1'b0, 1'b0, 5'd9);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0);
            check_cycle();
            if (k == 1) check_val("tp1_busy9", 32'(busy_vec[9]), 32'd1);
            if (k == 3) check_val("tp1_wb_addr", 32'(wb_addr), 32'd9);
            if (k == 4) check_val("tp1_busy9_clr", 32'(busy_vec[9]), 32'd0);
            advance();
        end

        // Three back-to-back writes to r5
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 3'd1, 5'd5, 1'b0, 1'b0, 5'd5);
        idle(5, 5'd5);

        // $ra issue followed by two stall cycles: writeback lands in cycle 5
        cyc(1'b1, 1'b1, 3'd2, 5'd0, 1'b0, 1'b0, 5'd31);
        cyc(1'b0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0, 5'd31);
        cyc(1'b0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b0, 5'd31);
        cyc(1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 5'd31);
        cyc(1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 5'd31);
        drive(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 5'd0);
        check_cycle();
        check_val("tp3_wb_valid", 32'(wb_valid), 32'd1);
        check_val("tp3_wb_addr", 32'(wb_addr), 32'd31);
        advance();
        idle(2, 5'd0);

        // Illegal select, then a write to r0
        cyc(1'b1, 1'b1, 3'd6, 5'd7, 1'b0, 1'b0, 5'd7);
        cyc(1'b1, 1'b1, 3'd1, 5'd0, 1'b0, 1'b0, 5'd0);
        idle(4, 5'd7);

        // Two in flight, then flush with a concurrent issue
        cyc(1'b1, 1'b1, 3'd1, 5'd12, 1'b0, 1'b0, 5'd12);
        cyc(1'b1, 1'b1, 3'd1, 5'd13, 1'b0, 1'b0, 5'd13);
        cyc(1'b1, 1'b1, 3'd1, 5'd14, 1'b1, 1'b1, 5'd14);
        check_cycle();
        check_val("tp5_busy_after_flush", busy_vec, 32'd0);
        advance();
        idle(4, 5'd12);

        // Single pending write to r7: hazard_a in the retire cycle
        cyc(1'b1, 1'b1, 3'd1, 5'd7, 1'b0, 1'b0, 5'd7);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7);
            check_cycle();
            if (k == 3) begin
                check_val("tp6_wb_valid", 32'(wb_valid), 32'd1);
                check_val("tp6_hazard_a", 32'(hazard_a), 32'(HAZ_AT_RETIRE));
            end
            advance();
        end
        idle(2, 5'd0);

        // Randomized traffic with occasional mid-operation reset
        for (int n = 0; n < 3000; n++) begin
            logic [2:0]    sel;
            logic [AW-1:0] rs, rt, rd, sa, sb;
            logic          do_rst;
            sel = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            sa  = 5'($urandom_range(0, 7));
            sb  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(29, 31)) : 5'($urandom_range(0, 7));
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, sel, rs, rt, rd,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3, sa, sb);
            do_rst = ($urandom_range(0, 199) == 0);
            if (do_rst) begin
                reset = 1'b1;
                pend.delete();
                err_exp = 1'b0;
            end
            check_cycle();
            if (do_rst) begin
                check_val("rnd_rst_busy", busy_vec, 32'd0);
                #1 reset = 1'b0;
            end
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_dest_track.md
Name: reg_dest_track

Overview:
- Parametrised successor to the register-destination selector.
- Selects the write-destination register from instruction fields or fixed constants ($ra, $sp).
- Carries the selected destination through a PIPE_DEPTH-stage writeback delay line.
- Keeps a per-register pending-write scoreboard so the control unit can detect RAW hazards on two source operands.
- Sits between the decode/control FSM and the register file write port.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (2**REG_ADDR_W).
- PIPE_DEPTH, 3, cycles from issue acceptance to writeback (1..8).
- RA_REG, 31, constant destination for sel=010.
- SP_REG, 29, constant destination for sel=011.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  a new instruction is presented.
- issue_wr  in  1  the instruction writes a register.
- dest_sel  in  3  destination select: 000 rt, 001 rd, 010 RA_REG, 011 SP_REG, 100 rs, 101-111 illegal.
- inst25_21  in  REG_ADDR_W  rs field.
- inst20_16  in  REG_ADDR_W  rt field.
- inst15_11  in  REG_ADDR_W  rd field.
- stall  in  1  freeze the delay line; no issue accepted.
- flush  in  1  synchronous discard of all in-flight entries.
- src_a  in  REG_ADDR_W  first source register to check.
- src_b  in  REG_ADDR_W  second source register to check.
- dest_addr  out  REG_ADDR_W  combinational selected destination (0 when sel is illegal).
- dest_err  out  1  registered; pulses one cycle after an accepted issue with an illegal sel.
- wb_valid  out  1  writeback strobe from the last stage.
- wb_addr  out  REG_ADDR_W  writeback register address.
- hazard_a  out  1  src_a has a pending write.
- hazard_b  out  1  src_b has a pending write.
- busy_vec  out  NUM_REGS  bit i = register i has at least one pending write.

Behaviour:
- Reset: all stages invalid; all counters 0; wb_valid=0, wb_addr=0, dest_err=0, hazard_a/b=0, busy_vec=0.
- Acceptance: issue accepted at the clock edge when issue_valid && !stall && !flush.
  - If issue_valid is high while stalled, the issue is not accepted; upstream holds it.
- Entry tracking: an entry is tracked only if issue_wr=1, dest_sel is legal, and dest_addr != 0.
  - Otherwise a bubble enters stage 0.
  - An illegal sel additionally sets dest_err for one cycle.
- Delay line: PIPE_DEPTH registered stages {valid, addr}, shifting on every edge with !stall.
  - Latency: issue accepted in cycle c gives wb_valid=1 in cycle c+PIPE_DEPTH (no stalls); each stall cycle adds one.
- Writeback strobe: wb_valid = last_stage.valid && !stall; wb_addr = last_stage.addr (0 when invalid).
  - A retire occurs in any cycle with wb_valid=1.
- Scoreboard: one counter per register, width $clog2(PIPE_DEPTH+1).
  - +1 on a tracked accept; -1 on retire.
  - Accept and retire to the same register in the same cycle: counter unchanged.
  - Counter can never exceed PIPE_DEPTH. Register 0 is never counted.
- Hazard outputs: busy_vec[i] = (cnt[i] != 0); hazard_a = busy_vec[src_a]; hazard_b = busy_vec[src_b].
  - All three are combinational from the registered counters.
- Flush: on the edge with flush=1, all stages become invalid and all counters become 0.
  - Any concurrent issue or retire is discarded.
  - flush has priority over stall.
- Reset mid-operation: asynchronous reset clears everything immediately; nothing in flight survives.

Optional Feature:
- Macro: REG_DEST_TRACK_BYPASS_EN.
- Defined: hazard_x is suppressed when cnt[src_x]==1 and the retiring entry (wb_valid && wb_addr==src_x) is that write. Register-file write-through bypass makes the value available this cycle. busy_vec is unaffected.
- Undefined: hazard_x follows busy_vec exactly; the hazard clears the cycle after retire.

Decomposition:
- Package reg_dest_pkg holds:
  - the dest_sel encoding constants (SEL_RT, SEL_RD, SEL_RA, SEL_SP, SEL_RS);
  - the default RA_REG/SP_REG values;
  - a stage struct typedef {valid, addr}.
- One natural sub-module, reg_dest_scoreboard: the per-register counters, busy_vec and the hazard compare. The top contains the select mux and the delay line.

Test Plan:
- Reset then issue sel=001, rd=9, wr=1 at cycle 0 -> busy_vec[9]=1 from cycle 1; wb_valid=1, wb_addr=9 at cycle 3; busy_vec[9]=0 at cycle 4.
- Issue to r5 on three consecutive cycles -> cnt[5] reaches 3; hazard_a (src_a=5) stays high until the third retire completes.
- Issue sel=010 with 2 stall cycles inserted after acceptance -> wb_addr=31 at cycle 5; wb_valid held low during stall.
- Issue sel=110 -> dest_err=1 for one cycle, no wb_valid, busy_vec unchanged. Issue rd=0 -> no tracking, no wb_valid.
- Two entries in flight plus flush concurrent with a new issue -> busy_vec=0 next cycle; no wb_valid afterwards.
- With REG_DEST_TRACK_BYPASS_EN: single pending write to r7, src_a=7 -> hazard_a=0 in the retire cycle. Without the macro, hazard_a=1 in that cycle.
